w25q64_cmd_seq: RTL

Command sequencer between user logic and the SPI byte-frame driver for the W25Q64 flash. It accepts one high-level operation at a time (read JEDEC ID, read byte, program byte, sector erase, read status) and builds the left-aligned SPI frames. For write and erase it inserts WRITE ENABLE, then polls the status register until BUSY clears. It returns a single response beat with data or an error flag.

---
 rtl/w25q64_pkg.sv | 41 ++++
 rtl/w25q64_cmd_seq_if.sv | 16 +
 rtl/w25q64_poll_timer.sv | 41 ++++
 rtl/w25q64_cmd_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/w25q64_pkg.sv
// Shared encodings for the W25Q64 command sequencer: user op codes, flash
// opcodes, FSM states and SPI frame field offsets.
package w25q64_pkg;

  typedef enum logic [2:0] {
    OP_READ_ID = 3'd0,
    OP_READ    = 3'd1,
    OP_PROGRAM = 3'd2,
    OP_ERASE4K = 3'd3,
    OP_STATUS  = 3'd4
  } op_e;

  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_JEDEC = 8'h9F;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_PP    = 8'h02;
  localparam logic [7:0] CMD_SE    = 8'h20;

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_WREN_WT, S_MAIN, S_MAIN_WT,
    S_GAP, S_POLL, S_POLL_WT, S_RESP
  } state_e;

  localparam int STATUS_BUSY_BIT = 0;

  // Bit offsets inside the left-aligned 40-bit frame
  localparam int CMD_LSB    = 32;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_LSB   = 0;
  localparam int STATUS_LSB = 24;

  function automatic logic is_legal(input logic [2:0] code);
    return code <= 3'd4;
  endfunction

  function automatic logic needs_wren(input logic [2:0] code);
    return (code == OP_PROGRAM) || (code == OP_ERASE4K);
  endfunction

endpackage

// File: rtl/w25q64_cmd_seq_if.sv
// User-side operation request / response channel of the flash sequencer.
interface w25q64_cmd_seq_if;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [23:0] op_addr;
  logic [7:0]  op_wdata;
  logic        rsp_valid;
  logic [23:0] rsp_data;
  logic        rsp_err;

  modport master (output op_valid, op_code, op_addr, op_wdata,
                  input  op_ready, rsp_valid, rsp_data, rsp_err);
  modport slave  (input  op_valid, op_code, op_addr, op_wdata,
                  output op_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/w25q64_poll_timer.sv
// Idle-gap down-counter between status polls plus the poll counter that
// flags the final allowed poll.
module w25q64_poll_timer #(
  parameter int POLL_GAP  = 1000,
  parameter int MAX_POLLS = 65535
) (
  input  logic i_sys_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic gap_start,
  input  logic poll_done,
  output logic gap_expired,
  output logic last_poll
);
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  logic [GAP_W-1:0] gap_cnt_reg;
  logic [15:0]      poll_cnt_reg;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      gap_cnt_reg  <= '0;
      poll_cnt_reg <= '0;
    end else begin
      // Loading POLL_GAP-1 makes the GAP state last exactly POLL_GAP cycles
      if (gap_start)
        gap_cnt_reg <= GAP_W'(POLL_GAP - 1);
      else if (gap_cnt_reg != '0)
        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);

      if (clear)
        poll_cnt_reg <= '0;
      else if (poll_done)
        poll_cnt_reg <= poll_cnt_reg + 16'd1;
    end
  end

  assign gap_expired = (gap_cnt_reg == '0);
  assign last_poll   = (poll_cnt_reg == 16'(MAX_POLLS - 1));

endmodule

// File: rtl/w25q64_cmd_seq.sv
// W25Q64 command sequencer: turns one user operation into WREN / command /
// status-poll SPI frames and returns a single response beat.
module w25q64_cmd_seq
  import w25q64_pkg::*;
#(
  parameter int FRAME_W   = 40,
  parameter int POLL_GAP  = 1000,
  parameter int MAX_POLLS = 65535
) (
  input  logic               i_sys_clk,
  input  logic               i_reset,
  w25q64_cmd_seq_if.slave    user,
  output logic [FRAME_W-1:0] spi_tx_data,
  output logic [2:0]         spi_len,
  output logic               spi_en,
  input  logic               spi_busy,
  input  logic               spi_done,
  input  logic [FRAME_W-1:0] spi_rx_data
);
  state_e state_reg, state_next;
  logic [2:0]         op_code_reg, op_code_next;
  logic [23:0]        addr_reg, addr_next;
  logic [7:0]         wdata_reg, wdata_next;
  logic [FRAME_W-1:0] tx_reg, tx_next;
  logic [2:0]         len_reg, len_next;
  logic [23:0]        rsp_data_reg, rsp_data_next;
  logic               rsp_err_reg, rsp_err_next;

  logic               accept, gap_start, poll_done, gap_expired, last_poll;
  logic [2:0]         cur_code;
  logic [23:0]        cur_addr;
  logic [7:0]         cur_wdata;
  logic [FRAME_W-1:0] main_frame, wren_frame, poll_frame;
  logic [2:0]         main_len;
  logic [7:0]         rx_status;
  logic               unused_inputs;

  // The command byte of a received frame and spi_busy carry nothing we need
  assign unused_inputs = ^{spi_busy, spi_rx_data[FRAME_W-1:CMD_LSB]};
  assign rx_status     = spi_rx_data[STATUS_LSB +: 8];

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_reg    <= S_IDLE;
      op_code_reg  <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      tx_reg       <= '0;
      len_reg      <= 3'd1;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_code_reg  <= op_code_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      tx_reg       <= tx_next;
      len_reg      <= len_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  // In IDLE the frame is built straight from the request so MAIN can start at once
  always_comb begin
    cur_code  = (state_reg == S_IDLE) ? user.op_code  : op_code_reg;
    cur_addr  = (state_reg == S_IDLE) ? user.op_addr  : addr_reg;
    cur_wdata = (state_reg == S_IDLE) ? user.op_wdata : wdata_reg;
    main_frame = '0;
    main_len   = 3'd2;
    case (cur_code)
      OP_READ_ID: begin
        main_frame[CMD_LSB +: 8] = CMD_JEDEC;
        main_len = 3'd4;
      end
      OP_READ: begin
        main_frame[CMD_LSB +: 8]   = CMD_READ;
        main_frame[ADDR_LSB +: 24] = cur_addr;
        main_len = 3'd5;
      end
      OP_PROGRAM: begin
        main_frame[CMD_LSB +: 8]   = CMD_PP;
        main_frame[ADDR_LSB +: 24] = cur_addr;
        main_frame[DATA_LSB +: 8]  = cur_wdata;
        main_len = 3'd5;
      end
      OP_ERASE4K: begin
        main_frame[CMD_LSB +: 8]   = CMD_SE;
        main_frame[ADDR_LSB +: 24] = cur_addr;
        main_len = 3'd4;
      end
      default: main_frame[CMD_LSB +: 8] = CMD_RDSR;
    endcase
    wren_frame = '0;
    wren_frame[CMD_LSB +: 8] = CMD_WREN;
    poll_frame = '0;
    poll_frame[CMD_LSB +: 8] = CMD_RDSR;
  end

  always_comb begin
    state_next    = state_reg;
    op_code_next  = op_code_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    tx_next       = tx_reg;
    len_next      = len_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    accept        = 1'b0;
    gap_start     = 1'b0;
    poll_done     = 1'b0;
    case (state_reg)
      S_IDLE: if (user.op_valid) begin
        accept       = 1'b1;
        op_code_next = user.op_code;
        addr_next    = user.op_addr;
        wdata_next   = user.op_wdata;
        if (!is_legal(user.op_code)) begin
          state_next    = S_RESP;
          rsp_err_next  = 1'b1;
          rsp_data_next = '0;
        end else if (needs_wren(user.op_code)) begin
          state_next = S_WREN;
          tx_next    = wren_frame;
          len_next   = 3'd1;
        end else begin
          state_next = S_MAIN;
          tx_next    = main_frame;
          len_next   = main_len;
        end
      end
      S_WREN:    state_next = S_WREN_WT;
      S_WREN_WT: if (spi_done) begin
        state_next = S_MAIN;
        tx_next    = main_frame;
        len_next   = main_len;
      end
      S_MAIN:    state_next = S_MAIN_WT;
      S_MAIN_WT: if (spi_done) begin
        if (needs_wren(op_code_reg)) begin
          state_next = S_GAP;
          gap_start  = 1'b1;
        end else begin
          state_next   = S_RESP;
          rsp_err_next = 1'b0;
          case (op_code_reg)
            OP_READ_ID: rsp_data_next = spi_rx_data[ADDR_LSB +: 24];
            OP_READ:    rsp_data_next = {16'h0, spi_rx_data[DATA_LSB +: 8]};
            default:    rsp_data_next = {16'h0, rx_status};
          endcase
        end
      end
      S_GAP: if (gap_expired) begin
        state_next = S_POLL;
        tx_next    = poll_frame;
        len_next   = 3'd2;
      end
      S_POLL:    state_next = S_POLL_WT;
      S_POLL_WT: if (spi_done) begin
        poll_done = 1'b1;
        if (!rx_status[STATUS_BUSY_BIT] || last_poll) begin
          state_next    = S_RESP;
          rsp_err_next  = rx_status[STATUS_BUSY_BIT];
          rsp_data_next = {16'h0, rx_status};
        end else begin
          state_next = S_GAP;
          gap_start  = 1'b1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  w25q64_poll_timer #(
    .POLL_GAP  (POLL_GAP),
    .MAX_POLLS (MAX_POLLS)
  ) u_poll_timer (
    .i_sys_clk   (i_sys_clk),
    .i_reset     (i_reset),
    .clear       (accept),
    .gap_start   (gap_start),
    .poll_done   (poll_done),
    .gap_expired (gap_expired),
    .last_poll   (last_poll)
  );

  assign user.op_ready  = (state_reg == S_IDLE) && !i_reset;
  assign user.rsp_valid = (state_reg == S_RESP) && !i_reset;
  assign user.rsp_data  = rsp_data_reg;
  assign user.rsp_err   = rsp_err_reg;
  assign spi_en      = ((state_reg == S_WREN) || (state_reg == S_MAIN) ||
                        (state_reg == S_POLL)) && !i_reset;
  assign spi_tx_data = tx_reg;
  assign spi_len     = len_reg;

endmodule
